// File: rtl/fifo_wr_arbiter_if.sv
// Bundle of signals between the write-side requesters, the async FIFO memory
// and the write-side arbiter. The master side is the requesters plus the
// read-pointer synchronizer; the slave side is the arbiter itself.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 9
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic [PTR_WIDTH:0]            wq2_rptr;
    logic                          write_enable;
    logic [DATA_WIDTH-1:0]         data_write;
    logic [PTR_WIDTH:0]            wptr;
    logic [PTR_WIDTH:0]            wptr_gray;
    logic                          wfull;

    modport master (
        output req_valid, req_data, req_last, wq2_rptr,
        input  req_ready, write_enable, data_write, wptr, wptr_gray, wfull
    );

    modport slave (
        input  req_valid, req_data, req_last, wq2_rptr,
        output req_ready, write_enable, data_write, wptr, wptr_gray, wfull
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Write-side controller of the async FIFO (wclk domain).
// Round-robin arbiter with packet locking in front of the single memory write
// port; owns the binary/gray write pointer and the registered full flag.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 9
) (
    input logic                wclk,
    input logic                wrst_n,
    fifo_wr_arbiter_if.slave   bus
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                 state_q;
    logic [IDX_W-1:0]       rr_last_q;
    logic [IDX_W-1:0]       owner_q;
    logic [PTR_WIDTH:0]     wptr_q;
    logic [PTR_WIDTH:0]     wptr_d;
    logic [PTR_WIDTH:0]     wptr_gray_q;
    logic [PTR_WIDTH:0]     wptr_gray_d;
    logic                   wfull_q;
    logic                   wfull_d;

    logic [IDX_W-1:0]       winner;
    logic [IDX_W-1:0]       sel;
    logic [NUM_REQ-1:0]     ready;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  data_sel;
    logic                   last_sel;

    // Rotating-priority search: first valid requester after the last grant.
    // With nobody valid the slot right after rr_last is offered, so ready
    // stays one-hot without waiting on that requester's own valid.
    always_comb begin : arbSearch
        logic [IDX_W-1:0] cand;
        logic             found;
        found  = 1'b0;
        cand   = '0;
        winner = IDX_W'((int'(rr_last_q) + 1) % NUM_REQ);
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(rr_last_q) + k) % NUM_REQ);
            if (!found && bus.req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign sel = (state_q == LOCKED) ? owner_q : winner;

    // Only the selected requester may be ready; nothing moves in reset or when full.
    always_comb begin
        ready = '0;
        if (wrst_n && !wfull_q) begin
            ready[sel] = 1'b1;
        end
    end

    // Route the selected requester's word and last flag to the memory port.
    always_comb begin
        data_sel = '0;
        last_sel = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDX_W'(i)) begin
                data_sel = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                last_sel = bus.req_last[i];
            end
        end
    end

    assign accept = |(bus.req_valid & ready);

    // Next pointer values and the full compare against the synced read pointer.
    always_comb begin
        wptr_d      = wptr_q + {{PTR_WIDTH{1'b0}}, accept};
        wptr_gray_d = wptr_d ^ (wptr_d >> 1);
        wfull_d     = (wptr_gray_d == {~bus.wq2_rptr[PTR_WIDTH:PTR_WIDTH-1],
                                        bus.wq2_rptr[PTR_WIDTH-2:0]});
    end

    // Arbitration FSM and write pointer registers.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state_q     <= IDLE;
            rr_last_q   <= IDX_W'(NUM_REQ - 1);
            owner_q     <= '0;
            wptr_q      <= '0;
            wptr_gray_q <= '0;
            wfull_q     <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            wptr_gray_q <= wptr_gray_d;
            wfull_q     <= wfull_d;
            if (accept) begin
                if (state_q == IDLE) begin
                    rr_last_q <= winner;
                    if (!last_sel) begin
                        state_q <= LOCKED;
                        owner_q <= winner;
                    end
                end else if (last_sel) begin
                    state_q <= IDLE;
                end
            end
        end
    end

    assign bus.req_ready    = ready;
    assign bus.write_enable = accept;
    assign bus.data_write   = data_sel;
    assign bus.wptr         = wptr_q;
    assign bus.wptr_gray    = wptr_gray_q;
    assign bus.wfull        = wfull_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a driver issues stimulus and pushes
// expected per-cycle state and expected memory writes; a monitor pops them.
`timescale 1ns/1ps
module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int PW    = 9;
    localparam int DEPTH = 512;
    localparam int PMOD  = 1024;

    typedef struct {
        bit            rstN;
        logic [NR-1:0] grant;
        bit            zero;
        logic [NR-1:0] allowed;
        int            wptr;
        bit            full;
    } CycleExp;

    typedef struct {
        logic [DW-1:0] data;
        int            addr;
    } WriteExp;

    CycleExp cycleQ[$];
    WriteExp writeQ[$];

    logic clk = 1'b0;
    logic rstN;

    fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) bus();

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
        .wclk   (clk),
        .wrst_n (rstN),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: occupancy arithmetic on plain integers.
    int mWptr;
    int mLast;
    int mOwner;
    int mWrites;
    bit mFull;
    int rptrCount;
    int rptrMode;
    int rptrPct;
    int wHist[$];

    function automatic logic [PW:0] toGray(input int n);
        logic [PW:0] b;
        b = n[PW:0];
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts this cycle's outputs and
    // then advances to the state after the coming rising edge.
    task automatic applyStimulus(input bit rst_n, input logic [NR-1:0] valid, input logic [NR-1:0] last);
        logic [NR*DW-1:0] data;
        int               lagged;
        int               winner;
        int               idx;
        int               nextW;
        CycleExp          ce;
        WriteExp          we;
        @(negedge clk);
        for (int i = 0; i < NR; i++) data[i*DW +: DW] = DW'($urandom);

        wHist.push_back(mWptr);
        if (wHist.size() > 3) void'(wHist.pop_front());
        lagged = (wHist.size() == 3) ? wHist[0] : 0;
        if (rptrMode == 1) begin
            rptrCount = lagged;
        end else if (rptrMode == 2) begin
            if (rptrCount != lagged && $urandom_range(0, 99) < rptrPct)
                rptrCount = (rptrCount + 1) % PMOD;
        end

        rstN          = rst_n;
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.req_last  = last;
        bus.wq2_rptr  = toGray(rptrCount);

        ce.rstN    = rst_n;
        ce.grant   = '0;
        ce.zero    = !rst_n || mFull;
        ce.allowed = (mOwner >= 0) ? NR'(1 << mOwner) : '1;
        ce.wptr    = mWptr;
        ce.full    = mFull;
        winner     = -1;
        if (!ce.zero) begin
            if (mOwner >= 0) begin
                winner = mOwner;
            end else begin
                for (int k = 1; k <= NR; k++) begin
                    idx = (mLast + k) % NR;
                    if (winner < 0 && valid[idx]) winner = idx;
                end
            end
            if (winner >= 0 && valid[winner]) ce.grant[winner] = 1'b1;
        end
        cycleQ.push_back(ce);

        if (|ce.grant) begin
            we.data = data[winner*DW +: DW];
            we.addr = mWptr % DEPTH;
            writeQ.push_back(we);
        end

        if (!rst_n) begin
            mWptr     = 0;
            mFull     = 1'b0;
            mLast     = NR - 1;
            mOwner    = -1;
            rptrCount = 0;
            wHist.delete();
        end else begin
            nextW = (mWptr + (|ce.grant ? 1 : 0)) % PMOD;
            mFull = (((nextW - rptrCount) + PMOD) % PMOD) == DEPTH;
            if (|ce.grant) begin
                mWrites++;
                mLast  = winner;
                mOwner = last[winner] ? -1 : winner;
            end
            mWptr = nextW;
        end
    endtask

    // Monitor: compares every cycle's state and every memory write strobe.
    initial begin : monitor
        CycleExp     ce;
        WriteExp     we;
        logic [PW:0] prevGray;
        bit          prevValid;
        prevGray  = '0;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (cycleQ.size() > 0) begin
                ce = cycleQ.pop_front();
                checkOutput("grant", 32'(bus.req_valid & bus.req_ready), 32'(ce.grant));
                checkOutput("write_enable", 32'(bus.write_enable), 32'(|ce.grant));
                checkOutput("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
                checkOutput("ready_outside_owner", 32'(bus.req_ready & ~ce.allowed), 32'd0);
                if (ce.zero) checkOutput("ready_blocked", 32'(bus.req_ready), 32'd0);
                checkOutput("wptr", 32'(bus.wptr), 32'(ce.wptr));
                checkOutput("wptr_gray", 32'(bus.wptr_gray), 32'(toGray(ce.wptr)));
                checkOutput("wfull", 32'(bus.wfull), 32'(ce.full));
                if (prevValid)
                    checkOutput("gray_single_step", 32'($countones(bus.wptr_gray ^ prevGray) <= 1), 32'd1);
                prevGray  = bus.wptr_gray;
                prevValid = ce.rstN;
            end
            if (bus.write_enable === 1'b1) begin
                if (writeQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_write: got write data 0x%0h expected no write at %0t",
                             bus.data_write, $time);
                end else begin
                    we = writeQ.pop_front();
                    checkOutput("data_write", 32'(bus.data_write), 32'(we.data));
                    checkOutput("write_addr", 32'(bus.wptr[PW-1:0]), 32'(we.addr));
                end
            end
        end
    end

    // Global time bound so the run always ends.
    initial begin : watchdog
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "[TB] time limit reached");
    end

    // Stimulus sequence: directed scenarios followed by a random run.
    initial begin : stimulus
        int guard;
        int startWrites;
        rstN          = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        bus.wq2_rptr  = '0;
        mWptr     = 0;
        mFull     = 1'b0;
        mLast     = NR - 1;
        mOwner    = -1;
        mWrites   = 0;
        rptrCount = 0;
        rptrMode  = 0;
        rptrPct   = 50;

        $display("[TB] reset with all requesters valid");
        repeat (2) applyStimulus(1'b0, 4'hF, 4'hF);

        $display("[TB] round-robin over single-word packets");
        repeat (5) applyStimulus(1'b1, 4'hF, 4'hF);

        $display("[TB] packet lock: req0 three words, req1 waiting");
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0011, 4'b0000);
        applyStimulus(1'b1, 4'b0011, 4'b0000);
        applyStimulus(1'b1, 4'b0011, 4'b0001);
        applyStimulus(1'b1, 4'b0011, 4'b0011);

        $display("[TB] fill to full, then release one slot");
        applyStimulus(1'b0, 4'h0, 4'h0);
        repeat (DEPTH) applyStimulus(1'b1, 4'hF, NR'($urandom));
        repeat (3) applyStimulus(1'b1, 4'hF, 4'hF);
        rptrCount = 1;
        repeat (4) applyStimulus(1'b1, 4'hF, 4'hF);

        $display("[TB] pointer wrap with a trailing reader");
        applyStimulus(1'b0, 4'h0, 4'h0);
        rptrMode    = 1;
        startWrites = mWrites;
        guard       = 0;
        while (mWrites - startWrites < 1100 && guard < 4000) begin
            applyStimulus(1'b1, NR'($urandom_range(1, 15)), NR'($urandom));
            guard++;
        end
        checkOutput("wrap_write_count", 32'(mWrites - startWrites), 32'd1100);

        $display("[TB] reset in the middle of a locked packet");
        rptrMode = 0;
        applyStimulus(1'b0, 4'h0, 4'h0);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        applyStimulus(1'b1, 4'b0100, 4'b0000);
        applyStimulus(1'b0, 4'b0101, 4'b0000);
        applyStimulus(1'b1, 4'b0101, 4'b0101);
        applyStimulus(1'b1, 4'b0101, 4'b0101);

        $display("[TB] random traffic with a variable-speed reader");
        rptrMode = 2;
        for (int i = 0; i < 2500; i++) begin
            if (i % 400 == 0) rptrPct = $urandom_range(5, 100);
            applyStimulus(($urandom_range(0, 299) != 0), NR'($urandom), NR'($urandom));
        end

        repeat (2) applyStimulus(1'b1, 4'h0, 4'h0);
        @(negedge clk);
        #2;
        checkOutput("pending_cycle_checks", 32'(cycleQ.size()), 32'd0);
        checkOutput("pending_writes", 32'(writeQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
